// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and BCD helpers for the display sharing controller.
package display_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
    localparam logic [7:0] BLANK_NUMBER = 8'h00;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic bcd_bad(input logic [7:0] v);
        return (v[7:4] > BCD_MAX) || (v[3:0] > BCD_MAX);
    endfunction
    function automatic logic [7:0] bcd_fix(input logic [7:0] v);
        return {(v[7:4] > BCD_MAX) ? 4'h0 : v[7:4], (v[3:0] > BCD_MAX) ? 4'h0 : v[3:0]};
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request searching upward from ptr, wrapping; one-hot result.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);
    logic [PW-1:0] j;
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = PW'((int'(ptr) + i) % N);
            if (!valid && req[j]) begin
                pick[j] = 1'b1;
                valid   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_share_ctrl.sv
// display_share_ctrl: round-robin sharing of the 2-digit display with minimum hold
// time and urgent preemption; drives a registered BCD pair plus blank flag.
module display_share_ctrl
    import display_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   urgent,
    input  logic [8*N_REQ-1:0] value,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         number,
    output logic               blank,
    output logic               bcd_err
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0]       number_q, number_d;
    logic             blank_q, blank_d;
    logic             bcd_err_q, bcd_err_d;

    logic [N_REQ-1:0] urg, u_pick, e_pick, o_pick, tgt;
    logic             e_valid, o_valid, sw, from_rr, owner_req;
    logic [PW-1:0]    tgt_idx;
    logic [7:0]       owner_val;

    assign urg       = req & urgent;
    assign u_pick    = urg & (~urg + N_REQ'(1));
    assign owner_req = |(grant_q & req);

    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_all (
        .req(req), .ptr(rr_q), .pick(e_pick), .valid(e_valid)
    );
    // Re-arbitration after hold expiry excludes the owner so it only keeps
    // the display when nobody else is asking.
    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_open (
        .req(req & ~grant_q), .ptr(rr_q), .pick(o_pick), .valid(o_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        tgt     = '0;
        sw      = 1'b0;
        from_rr = 1'b0;
        tgt_idx = '0;
        if (state_q == IDLE) begin
            if (|req) begin
                sw      = 1'b1;
                from_rr = 1'b1;
                tgt     = (|urg) ? u_pick : e_pick;
            end
        end else if ((|urg) && (u_pick != grant_q)) begin
            sw  = 1'b1;
            tgt = u_pick;
        end else if (!owner_req) begin
            if (e_valid) begin
                sw      = 1'b1;
                from_rr = 1'b1;
                tgt     = e_pick;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        end else if (state_q == HOLD) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(HOLD_CYCLES - 2)) ? OPEN : HOLD;
        end else if (o_valid) begin
            sw      = 1'b1;
            from_rr = 1'b1;
            tgt     = o_pick;
        end
        for (int i = 0; i < N_REQ; i++)
            if (tgt[i]) tgt_idx = PW'(i);
        if (sw) begin
            grant_d = tgt;
            state_d = HOLD;
            cnt_d   = '0;
            if (from_rr) rr_d = (tgt_idx == PW'(N_REQ - 1)) ? '0 : tgt_idx + PW'(1);
        end
    end

    always_comb begin
        owner_val = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_d[i]) owner_val = value[8*i +: 8];
        blank_d   = ~|grant_d;
        number_d  = blank_d ? BLANK_NUMBER : bcd_fix(owner_val);
        bcd_err_d = !blank_d && bcd_bad(owner_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            number_q  <= BLANK_NUMBER;
            blank_q   <= 1'b1;
            bcd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            number_q  <= number_d;
            blank_q   <= blank_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign grant   = grant_q;
    assign number  = number_q;
    assign blank   = blank_q;
    assign bcd_err = bcd_err_q;
endmodule

// File: tb/tb_display_share_ctrl.sv
// tb_display_share_ctrl: table-driven vectors with a scoreboard queue of expected
// outputs, plus hand-written reset and rotation sequences.
module tb_display_share_ctrl;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] urg;
        logic [7:0] v0;
        logic [3:0] g;
        logic [7:0] n;
        logic       b;
        logic       e;
    } vec_t;
    typedef struct {
        logic [3:0] g;
        logic [7:0] n;
        logic       b;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  urgent = '0;
    logic [31:0] value = 32'h7856_3412;
    logic [3:0]  grant;
    logic [7:0]  number;
    logic        blank;
    logic        bcd_err;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    exp_t sb[$];
    logic [7:0] vals [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    display_share_ctrl #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .urgent(urgent), .value(value),
        .grant(grant), .number(number), .blank(blank), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] u, input logic [7:0] v0,
                       input logic [3:0] g, input logic [7:0] n, input logic b, input logic e);
        vecs.push_back('{rst, r, u, v0, g, n, b, e});
    endtask

    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req = r;
        urgent = '0;
        #1;
        chk("rst_grant", {4'h0, grant}, 8'h00);
        chk("rst_blank", {7'h0, blank}, 8'h01);
        chk("rst_number", number, 8'h00);
        chk("rst_bcd_err", {7'h0, bcd_err}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input vec_t v);
        exp_t x;
        @(negedge clk);
        req = v.req;
        urgent = v.urg;
        value = {8'h78, 8'h56, 8'h34, v.v0};
        sb.push_back('{v.g, v.n, v.b, v.e});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("grant", {4'h0, grant}, {4'h0, x.g});
        chk("number", number, x.n);
        chk("blank", {7'h0, blank}, {7'h0, x.b});
        chk("bcd_err", {7'h0, bcd_err}, {7'h0, x.e});
    endtask

    initial begin
        // release then switch on drop, then idle
        add(0, 4'b0101, 4'b0000, 8'h12, 4'b0001, 8'h12, 0, 0);
        add(0, 4'b0101, 4'b0000, 8'h12, 4'b0001, 8'h12, 0, 0);
        add(0, 4'b0101, 4'b0000, 8'h12, 4'b0001, 8'h12, 0, 0);
        add(0, 4'b0100, 4'b0000, 8'h12, 4'b0100, 8'h56, 0, 0);
        add(0, 4'b0000, 4'b0000, 8'h12, 4'b0000, 8'h00, 1, 0);
        add(0, 4'b0000, 4'b0000, 8'h12, 4'b0000, 8'h00, 1, 0);
        // urgent preemption and counter restart for the preemptor
        add(1, 4'b0010, 4'b0000, 8'h12, 4'b0010, 8'h34, 0, 0);
        add(0, 4'b0010, 4'b0000, 8'h12, 4'b0010, 8'h34, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1010, 4'b1000, 8'h12, 4'b1000, 8'h78, 0, 0);
        add(0, 4'b1110, 4'b1100, 8'h12, 4'b0100, 8'h56, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b1110, 4'b0000, 8'h12, 4'b0100, 8'h56, 0, 0);
        add(0, 4'b1110, 4'b0000, 8'h12, 4'b1000, 8'h78, 0, 0);
        // invalid BCD scrubbing
        add(1, 4'b0001, 4'b0000, 8'h3A, 4'b0001, 8'h30, 0, 1);
        add(0, 4'b0001, 4'b0000, 8'h3A, 4'b0001, 8'h30, 0, 1);
        add(0, 4'b0001, 4'b0000, 8'h42, 4'b0001, 8'h42, 0, 0);
        add(0, 4'b0001, 4'b0000, 8'hC5, 4'b0001, 8'h05, 0, 1);
        add(0, 4'b0001, 4'b0000, 8'hFF, 4'b0001, 8'h00, 0, 1);
        // lone requester keeps the display past hold expiry
        for (int i = 0; i < 12; i++) add(i == 0, 4'b0100, 4'b0000, 8'h12, 4'b0100, 8'h56, 0, 0);

        do_reset(4'b0101);
        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset(vecs[k].req);
            step(vecs[k]);
        end

        // steady full request: each owner exactly 8 cycles in rotation
        do_reset(4'b1111);
        for (int c = 0; c < 40; c++) begin
            vec_t v;
            int o;
            o = (c / 8) % 4;
            v = '{0, 4'b1111, 4'b0000, 8'h12, 4'(1 << o), vals[o], 0, 0};
            step(v);
        end

        chk("sb_drained", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
